fetch_pc_unit: RTL and testbench
================================

Name: fetch_pc_unit

Overview:
IF-stage PC generator and IF/ID pipeline register. It sits directly upstream of the dynamic branch predictor: it drives `pc` to instruction memory and to the predictor. It consumes the predictor's `prediction`/`label` (IF), its `correct`/`error`/`new_label` (MEM), and the resolved `pcsrc`/target.
- Applies redirect / stall / predicted-taken priority.
- Produces the IF/ID register contents and the pipeline flush pulse.
- Keeps branch and mispredict statistics counters.

Parameters:
DATA_WIDTH, 32, width of PC, instruction and target buses
RESET_PC, 32'h0000_0000, PC value loaded on reset
CNT_WIDTH, 32, width of statistics counters
NOP_INSTR, 32'h0000_0013, bubble instruction inserted into IF/ID (addi x0,x0,0)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
load_use_flag  in  1  hazard stall: hold PC and IF/ID
pcsrc  in  1  branch resolved taken (MEM)
branch_target_M  in  DATA_WIDTH  resolved taken target (MEM)
branch_M  in  1  a conditional branch is in MEM this cycle
correct  in  1  MEM branch prediction matched outcome
error  in  1  MEM branch predicted taken, actually not taken
new_label  in  DATA_WIDTH  fall-through address (pc_M+4) for error recovery
prediction  in  1  IF predict-taken for current pc
label  in  DATA_WIDTH  IF predicted target for current pc
instr_F  in  DATA_WIDTH  instruction read combinationally at pc
pc  out  DATA_WIDTH  current fetch PC
pc_D  out  DATA_WIDTH  IF/ID PC
instr_D  out  DATA_WIDTH  IF/ID instruction
valid_D  out  1  IF/ID holds a real instruction
flush_pipe  out  1  combinational redirect pulse to flush ID/EX and EX/MEM
branch_cnt  out  CNT_WIDTH  branches resolved
mispredict_cnt  out  CNT_WIDTH  redirects taken

Behaviour:
- Reset (rst=0, async): pc=RESET_PC, pc_D=0, instr_D=NOP_INSTR, valid_D=0, both counters=0, state=BOOT.
- FSM with two states:
  - BOOT: one cycle after reset release. pc holds RESET_PC; IF/ID captures a bubble; next state is RUN. Redirect and stall inputs are ignored in BOOT. flush_pipe=0.
  - RUN: remains in RUN until reset.
- Terms:
  - mispred_nt = pcsrc & ~correct.
  - redirect = (state==RUN) & (error | mispred_nt).
  - flush_pipe = redirect.
- Next pc in RUN, priority high to low:
  1. error -> new_label
  2. mispred_nt -> branch_target_M
  3. load_use_flag -> hold pc
  4. prediction -> label
  5. otherwise pc+4, modulo 2^DATA_WIDTH (wraps at all-ones).
- Redirect overrides load_use_flag: the stalled instruction is younger and is squashed.
- error and mispred_nt are mutually exclusive, because error implies pcsrc=0. If both are high, error wins; the bench flags the condition with an assertion.
- IF/ID register in RUN:
  - redirect: bubble (instr_D=NOP_INSTR, pc_D=0, valid_D=0).
  - else load_use_flag: hold all three.
  - else: pc_D=pc, instr_D=instr_F, valid_D=1.
- Latency: a redirect asserted in cycle N puts the target on pc in cycle N+1. Its instruction appears in IF/ID in cycle N+2.
- Counters:
  - branch_cnt increments when branch_M & state==RUN.
  - mispredict_cnt increments on redirect.
  - Both saturate at all-ones and are unaffected by load_use_flag.
- Reset asserted mid-operation immediately restores all reset values. BOOT is re-entered on release.

Decomposition:
- Shared package holds:
  - FSM state encoding (BOOT=1'b0, RUN=1'b1)
  - NOP constant 32'h0000_0013
  - branch opcode 7'b1100011
  - PC increment constant 4
- Natural sub-module: sat_counter, a parameterised saturating up-counter with async active-low reset. It is instantiated twice, for branch_cnt and mispredict_cnt.

Test Plan:
- Reset release with RESET_PC=0x100 and no prediction -> pc sequence 0x100 (BOOT), 0x100, 0x104, 0x108. valid_D is 0 until pc_D=0x100 appears, then 1.
- Predicted taken: at pc=0x104 drive prediction=1, label=0x080 -> next pc=0x080; pc_D=0x104, valid_D=1; flush_pipe=0.
- Error recovery: error=1, new_label=0x114, branch_M=1, load_use_flag=1 in the same cycle -> flush_pipe=1; next pc=0x114; IF/ID bubble (instr_D=0x13, valid_D=0); branch_cnt+1, mispredict_cnt+1.
- Not-taken mispredict: pcsrc=1, correct=0, branch_target_M=0x200, prediction=1, label=0x300 -> next pc=0x200, not 0x300; mispredict_cnt+1.
- Load-use stall for 2 cycles at pc=0x010 -> pc stays 0x010; pc_D/instr_D unchanged; on release pc=0x014.
- Saturation and wrap: preset CNT_WIDTH=4 and issue 20 redirects -> mispredict_cnt=15. With pc=0xFFFF_FFFC, no prediction and no stall -> next pc=0x0000_0000.

Source files
------------

// File: rtl/fetch_pc_unit_pkg.sv
// Shared definitions for the IF-stage PC generator: FSM encoding and fetch constants.
package fetch_pc_unit_pkg;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR_C   = 32'h0000_0013;
  localparam logic [6:0]  BRANCH_OPCODE = 7'b1100011;
  localparam int unsigned PC_INC        = 4;

endpackage

// File: rtl/fetch_pc_unit_sat_counter.sv
// Saturating up-counter with asynchronous active-low reset; holds at all-ones.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
    return (&v) ? v : v + WIDTH'(1);
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= sat_inc(cnt);
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// IF-stage PC generator with IF/ID register, redirect flush and branch statistics.
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    CNT_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = DATA_WIDTH'(NOP_INSTR_C)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_use_flag,
  input  logic                  pcsrc,
  input  logic [DATA_WIDTH-1:0] branch_target_M,
  input  logic                  branch_M,
  input  logic                  correct,
  input  logic                  error,
  input  logic [DATA_WIDTH-1:0] new_label,
  input  logic                  prediction,
  input  logic [DATA_WIDTH-1:0] label,
  input  logic [DATA_WIDTH-1:0] instr_F,
  output logic [DATA_WIDTH-1:0] pc,
  output logic [DATA_WIDTH-1:0] pc_D,
  output logic [DATA_WIDTH-1:0] instr_D,
  output logic                  valid_D,
  output logic                  flush_pipe,
  output logic [CNT_WIDTH-1:0]  branch_cnt,
  output logic [CNT_WIDTH-1:0]  mispredict_cnt
);

  fetch_state_e          state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_p0;
  logic [DATA_WIDTH-1:0] pc_p1, instr_p1;
  logic                  vld_p1;
  logic                  mispred_nt, redirect, in_run;

  assign in_run     = (state_q == RUN);
  assign mispred_nt = pcsrc & ~correct;
  // error implies pcsrc=0, so the two redirect sources never legitimately overlap
  assign redirect   = in_run & (error | mispred_nt);
  assign flush_pipe = redirect;

  always_comb begin
    state_d  = state_q;
    pc_p0    = pc;
    pc_p1    = pc_D;
    instr_p1 = instr_D;
    vld_p1   = valid_D;
    if (!in_run) begin
      state_d  = RUN;
      pc_p0    = RESET_PC;
      pc_p1    = '0;
      instr_p1 = NOP_INSTR;
      vld_p1   = 1'b0;
    end else begin
      if (error)              pc_p0 = new_label;
      else if (mispred_nt)    pc_p0 = branch_target_M;
      else if (load_use_flag) pc_p0 = pc;
      else if (prediction)    pc_p0 = label;
      else                    pc_p0 = pc + DATA_WIDTH'(PC_INC);

      // a redirect squashes the stalled, younger instruction
      if (redirect) begin
        pc_p1    = '0;
        instr_p1 = NOP_INSTR;
        vld_p1   = 1'b0;
      end else if (!load_use_flag) begin
        pc_p1    = pc;
        instr_p1 = instr_F;
        vld_p1   = 1'b1;
      end
    end
  end

  // IF stage -> IF/ID boundary
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= BOOT;
      pc      <= RESET_PC;
      pc_D    <= '0;
      instr_D <= NOP_INSTR;
      valid_D <= 1'b0;
    end else begin
      state_q <= state_d;
      pc      <= pc_p0;
      pc_D    <= pc_p1;
      instr_D <= instr_p1;
      valid_D <= vld_p1;
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_branch_cnt (
    .clk (clk),
    .rst (rst),
    .inc (branch_M & in_run),
    .cnt (branch_cnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_mispredict_cnt (
    .clk (clk),
    .rst (rst),
    .inc (redirect),
    .cnt (mispredict_cnt)
  );

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit with a cycle-level reference model and per-cycle compare.
module tb_fetch_pc_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam int          CMAX   = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_use_flag, pcsrc, branch_M, correct, error, prediction;
  logic [31:0] branch_target_M, new_label, label, instr_F;
  logic [31:0] pc, pc_D, instr_D;
  logic        valid_D, flush_pipe;
  logic [3:0]  branch_cnt, mispredict_cnt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_fn(input logic [31:0] p);
    return {p[31:2], 2'b11} ^ 32'h5A5A_0000;
  endfunction

  assign instr_F = instr_fn(pc);

  fetch_pc_unit #(
    .DATA_WIDTH (32),
    .RESET_PC   (RST_PC),
    .CNT_WIDTH  (4),
    .NOP_INSTR  (NOP)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .load_use_flag   (load_use_flag),
    .pcsrc           (pcsrc),
    .branch_target_M (branch_target_M),
    .branch_M        (branch_M),
    .correct         (correct),
    .error           (error),
    .new_label       (new_label),
    .prediction      (prediction),
    .label           (label),
    .instr_F         (instr_F),
    .pc              (pc),
    .pc_D            (pc_D),
    .instr_D         (instr_D),
    .valid_D         (valid_D),
    .flush_pipe      (flush_pipe),
    .branch_cnt      (branch_cnt),
    .mispredict_cnt  (mispredict_cnt)
  );

  // reference model: what the fetch unit must hold after each clock
  logic        m_boot, m_vld, m_redir;
  logic [31:0] m_pc, m_pcD, m_instrD;
  int          m_b, m_m;

  assign m_redir = error || (pcsrc && !correct);

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_boot <= 1'b1; m_pc <= RST_PC; m_pcD <= 32'h0; m_instrD <= NOP; m_vld <= 1'b0;
      m_b <= 0; m_m <= 0;
    end else if (m_boot) begin
      m_boot <= 1'b0; m_pc <= RST_PC; m_pcD <= 32'h0; m_instrD <= NOP; m_vld <= 1'b0;
    end else begin
      if (branch_M) m_b <= (m_b == CMAX) ? CMAX : m_b + 1;
      if (m_redir)  m_m <= (m_m == CMAX) ? CMAX : m_m + 1;
      if (m_redir) begin
        m_pcD <= 32'h0; m_instrD <= NOP; m_vld <= 1'b0;
      end else if (!load_use_flag) begin
        m_pcD <= m_pc; m_instrD <= instr_fn(m_pc); m_vld <= 1'b1;
      end
      if (error)                   m_pc <= new_label;
      else if (pcsrc && !correct)  m_pc <= branch_target_M;
      else if (load_use_flag)      m_pc <= m_pc;
      else if (prediction)         m_pc <= label;
      else                         m_pc <= 32'((64'(m_pc) + 64'd4) % 64'h1_0000_0000);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("cmp_pc",      pc,                  m_pc);
    chk("cmp_pc_D",    pc_D,                m_pcD);
    chk("cmp_instr_D", instr_D,             m_instrD);
    chk("cmp_valid_D", 32'(valid_D),        32'(m_vld));
    chk("cmp_flush",   32'(flush_pipe),     32'(!m_boot && m_redir));
    chk("cmp_bcnt",    32'(branch_cnt),     32'(m_b));
    chk("cmp_mcnt",    32'(mispredict_cnt), 32'(m_m));
  end

  always @(negedge clk) begin
    if (rst) assert (!(error && pcsrc)) else $error("error and pcsrc asserted together");
  end

  task automatic idle();
    load_use_flag = 0; pcsrc = 0; branch_M = 0; correct = 0; error = 0; prediction = 0;
    branch_target_M = 32'h0; new_label = 32'h0; label = 32'h0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b0;
    idle();
    repeat (3) step();
    chk("rst_pc",      pc,                  RST_PC);
    chk("rst_pc_D",    pc_D,                32'h0);
    chk("rst_instr_D", instr_D,             NOP);
    chk("rst_valid_D", 32'(valid_D),        32'h0);
    chk("rst_cnts",    32'({branch_cnt, mispredict_cnt}), 32'h0);

    // BOOT cycle: redirect, stall and branch inputs must be ignored
    rst = 1'b1;
    error = 1; new_label = 32'h500; branch_M = 1; load_use_flag = 1;
    #1 chk("boot_flush", 32'(flush_pipe), 32'h0);
    step(); idle();
    chk("boot_pc",    pc,               32'h100);
    chk("boot_valid", 32'(valid_D),     32'h0);
    chk("boot_bcnt",  32'(branch_cnt),  32'h0);
    step();
    chk("run_pc",    pc,   32'h104);
    chk("run_pc_D",  pc_D, 32'h100);
    chk("run_valid", 32'(valid_D), 32'h1);

    // predicted taken
    prediction = 1; label = 32'h080;
    #1 chk("pred_flush", 32'(flush_pipe), 32'h0);
    step(); idle();
    chk("pred_pc",       pc,   32'h080);
    chk("pred_model_pc", m_pc, 32'h080);
    chk("pred_pc_D",     pc_D, 32'h104);
    step();
    chk("seq_pc", pc, 32'h084);

    // error recovery overriding a stall
    error = 1; new_label = 32'h114; branch_M = 1; load_use_flag = 1;
    #1 chk("err_flush", 32'(flush_pipe), 32'h1);
    step(); idle();
    chk("err_pc",      pc,                  32'h114);
    chk("err_instr_D", instr_D,             32'h13);
    chk("err_valid",   32'(valid_D),        32'h0);
    chk("err_bcnt",    32'(branch_cnt),     32'h1);
    chk("err_mcnt",    32'(mispredict_cnt), 32'h1);
    step();
    chk("err_next_pc_D", pc_D, 32'h114);

    // not-taken mispredict beats a live prediction
    pcsrc = 1; correct = 0; branch_target_M = 32'h200; prediction = 1; label = 32'h300; branch_M = 1;
    #1 chk("mnt_flush", 32'(flush_pipe), 32'h1);
    step(); idle();
    chk("mnt_pc",   pc,                  32'h200);
    chk("mnt_mcnt", 32'(mispredict_cnt), 32'h2);

    // correctly predicted taken branch: counted, no redirect
    pcsrc = 1; correct = 1; branch_M = 1; branch_target_M = 32'h900;
    #1 chk("ok_flush", 32'(flush_pipe), 32'h0);
    step(); idle();
    chk("ok_pc",   pc,              32'h204);
    chk("ok_bcnt", 32'(branch_cnt), 32'h3);

    // load-use stall at 0x010, prediction must not move pc
    error = 1; new_label = 32'h00C;
    step(); idle();
    step();
    chk("pre_stall_pc", pc, 32'h010);
    load_use_flag = 1; prediction = 1; label = 32'h700;
    repeat (2) begin
      step();
      chk("stall_pc",      pc,      32'h010);
      chk("stall_pc_D",    pc_D,    32'h00C);
      chk("stall_instr_D", instr_D, 32'h5A5A_000F);
    end
    idle();
    step();
    chk("unstall_pc",   pc,   32'h014);
    chk("unstall_pc_D", pc_D, 32'h010);

    // pc wraps at all-ones
    error = 1; new_label = 32'hFFFF_FFFC;
    step(); idle();
    chk("wrap_pre", pc, 32'hFFFF_FFFC);
    step();
    chk("wrap_pc",   pc,   32'h0000_0000);
    chk("wrap_pc_D", pc_D, 32'hFFFF_FFFC);

    // 20 redirects saturate both 4-bit counters
    for (int i = 0; i < 20; i++) begin
      branch_M = 1;
      if (i % 2 == 0) begin
        error = 1; new_label = 32'h40 + 32'(i) * 8;
      end else begin
        pcsrc = 1; correct = 0; branch_target_M = 32'h800 + 32'(i) * 8;
      end
      step(); idle();
    end
    chk("sat_mcnt",       32'(mispredict_cnt), 32'd15);
    chk("sat_bcnt",       32'(branch_cnt),     32'd15);
    chk("sat_model_mcnt", 32'(m_m),            32'd15);

    // asynchronous reset mid-cycle, then BOOT again
    step(); step();
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_pc",    pc,                  RST_PC);
    chk("mid_rst_instr", instr_D,             NOP);
    chk("mid_rst_valid", 32'(valid_D),        32'h0);
    chk("mid_rst_mcnt",  32'(mispredict_cnt), 32'h0);
    step();
    rst = 1'b1;
    step();
    chk("reboot_pc",    pc,           32'h100);
    chk("reboot_valid", 32'(valid_D), 32'h0);
    step();
    chk("reboot_pc2",  pc,   32'h104);
    chk("reboot_pc_D", pc_D, 32'h100);
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
